// File: rtl/sata_oob_controller_if.sv
// OOB sequencer <-> PHY/platform bundle.
// master: the sequencer (drives tx/status); slave: PHY side and link-layer observers.
interface sata_oob_controller_if;
   logic        platform_ready;
   logic        oob_restart;
   logic        comm_init_detect;
   logic        comm_wake_detect;
   logic        rx_elec_idle;
   logic        rx_byte_is_aligned;
   logic [31:0] phy_rx_din;
   logic [3:0]  phy_rx_isk;
   logic        tx_comm_reset;
   logic        tx_comm_wake;
   logic        tx_elec_idle;
   logic [31:0] phy_tx_dout;
   logic        phy_tx_isk;
   logic        linkup;
   logic [3:0]  oob_state;
   logic [7:0]  retry_count;

   modport master (
      input  platform_ready, oob_restart,
      input  comm_init_detect, comm_wake_detect,
      input  rx_elec_idle, rx_byte_is_aligned,
      input  phy_rx_din, phy_rx_isk,
      output tx_comm_reset, tx_comm_wake,
      output tx_elec_idle,
      output phy_tx_dout, phy_tx_isk,
      output linkup, oob_state, retry_count
   );

   modport slave (
      output platform_ready, oob_restart,
      output comm_init_detect, comm_wake_detect,
      output rx_elec_idle, rx_byte_is_aligned,
      output phy_rx_din, phy_rx_isk,
      input  tx_comm_reset, tx_comm_wake,
      input  tx_elec_idle,
      input  phy_tx_dout, phy_tx_isk,
      input  linkup, oob_state, retry_count
   );
endinterface

// File: rtl/sata_oob_controller.sv
// Host-side SATA OOB / link bring-up sequencer (COMRESET, COMWAKE, D10.2, ALIGN).
// Ports: clk, rst_n (sync, active low), oob (sata_oob_controller_if.master bundle).
module sata_oob_controller #(
   parameter int COMM_PULSE    = 16,
   parameter int INIT_TIMEOUT  = 66000,
   parameter int ALIGN_TIMEOUT = 65535,
   parameter int SYNC_COUNT    = 3,
   parameter int LOSS_CYCLES   = 1024
) (
   input logic                  clk,
   input logic                  rst_n,
   sata_oob_controller_if.master oob
);

   localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
   localparam logic [31:0] D10_P   = 32'h4A4A4A4A;

   localparam int TMAX0 = (INIT_TIMEOUT > ALIGN_TIMEOUT) ?
                          INIT_TIMEOUT : ALIGN_TIMEOUT;
   localparam int TMAX  = (TMAX0 > COMM_PULSE) ?
                          TMAX0 : COMM_PULSE;
   localparam int CW = $clog2(TMAX + 1);
   localparam int LW = $clog2(LOSS_CYCLES + 1);
   localparam int SW = $clog2(SYNC_COUNT + 1);

   localparam logic [CW-1:0] PULSE_END = CW'(COMM_PULSE - 1);
   localparam logic [CW-1:0] INIT_END  = CW'(INIT_TIMEOUT - 1);
   localparam logic [CW-1:0] ALIGN_END = CW'(ALIGN_TIMEOUT - 1);
   localparam logic [LW-1:0] LOSS_END  = LW'(LOSS_CYCLES - 1);
   localparam logic [SW-1:0] SYNC_END  = SW'(SYNC_COUNT - 1);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_SEND_RESET = 4'd1,
      S_WAIT_INIT  = 4'd2,
      S_SEND_WAKE  = 4'd3,
      S_WAIT_WAKE  = 4'd4,
      S_WAIT_NOIDL = 4'd5,
      S_SEND_D10   = 4'd6,
      S_SEND_ALIGN = 4'd7,
      S_READY      = 4'd8
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_enter;
   logic          w_retry;
   logic          w_rx_align;
   logic          w_cnt_en;
   logic [CW-1:0] r_cnt;
   logic [LW-1:0] r_loss;
   logic [SW-1:0] r_sync;
   logic [7:0]    r_retry;

   logic          w_tx_reset;
   logic          w_tx_wake;
   logic          w_tx_idle;
   logic [31:0]   w_tx_dout;
   logic          w_tx_isk;
   logic          w_linkup;

   logic          r_tx_reset;
   logic          r_tx_wake;
   logic          r_tx_idle;
   logic [31:0]   r_tx_dout;
   logic          r_tx_isk;
   logic          r_linkup;

   assign w_rx_align = (oob.phy_rx_din == ALIGN_P) &&
                       (oob.phy_rx_isk == 4'b0001);

   // Next state. Detects are tested before timeouts so a
   // simultaneous detect wins; restart and platform loss override.
   always_comb begin
      w_next  = r_state;
      w_enter = 1'b0;
      w_retry = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (oob.platform_ready)
               w_next = S_SEND_RESET;
         end
         S_SEND_RESET: begin
            if (r_cnt == PULSE_END)
               w_next = S_WAIT_INIT;
         end
         S_WAIT_INIT: begin
            if (oob.comm_init_detect) begin
               w_next = S_SEND_WAKE;
            end else if (r_cnt == INIT_END) begin
               w_next  = S_SEND_RESET;
               w_retry = 1'b1;
            end
         end
         S_SEND_WAKE: begin
            if (r_cnt == PULSE_END)
               w_next = S_WAIT_WAKE;
         end
         S_WAIT_WAKE: begin
            if (oob.comm_wake_detect) begin
               w_next = S_WAIT_NOIDL;
            end else if (r_cnt == INIT_END) begin
               w_next  = S_SEND_RESET;
               w_retry = 1'b1;
            end
         end
         S_WAIT_NOIDL: begin
            if (!oob.rx_elec_idle) begin
               w_next = S_SEND_D10;
            end else if (r_cnt == INIT_END) begin
               w_next  = S_SEND_RESET;
               w_retry = 1'b1;
            end
         end
         S_SEND_D10: begin
            if (w_rx_align && oob.rx_byte_is_aligned) begin
               w_next = S_SEND_ALIGN;
            end else if (r_cnt == ALIGN_END) begin
               w_next  = S_SEND_RESET;
               w_retry = 1'b1;
            end
         end
         S_SEND_ALIGN: begin
            if (!w_rx_align && r_sync == SYNC_END) begin
               w_next = S_READY;
            end else if (r_cnt == ALIGN_END) begin
               w_next  = S_SEND_RESET;
               w_retry = 1'b1;
            end
         end
         S_READY: begin
            if (oob.comm_init_detect ||
                (oob.rx_elec_idle && r_loss == LOSS_END))
               w_next = S_SEND_RESET;
         end
         default: w_next = S_IDLE;
      endcase
      if (w_next != r_state)
         w_enter = 1'b1;
      // Restart re-enters SEND_RESET even from SEND_RESET,
      // so the pulse timer starts over.
      if (oob.oob_restart) begin
         w_next  = S_SEND_RESET;
         w_enter = 1'b1;
         w_retry = 1'b0;
      end
      if (!oob.platform_ready) begin
         w_next  = S_IDLE;
         w_enter = 1'b1;
         w_retry = 1'b0;
      end
   end

   // Output decode of the state being entered, so the
   // registered outputs line up with oob_state.
   always_comb begin
      w_tx_reset = 1'b0;
      w_tx_wake  = 1'b0;
      w_tx_idle  = 1'b1;
      w_tx_dout  = 32'h0;
      w_tx_isk   = 1'b0;
      w_linkup   = 1'b0;
      unique case (w_next)
         S_SEND_RESET: w_tx_reset = 1'b1;
         S_SEND_WAKE:  w_tx_wake  = 1'b1;
         S_SEND_D10: begin
            w_tx_idle = 1'b0;
            w_tx_dout = D10_P;
         end
         S_SEND_ALIGN: begin
            w_tx_idle = 1'b0;
            w_tx_dout = ALIGN_P;
            w_tx_isk  = 1'b1;
         end
         S_READY: begin
            w_tx_idle = 1'b0;
            w_tx_dout = ALIGN_P;
            w_tx_isk  = 1'b1;
            w_linkup  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_cnt_en = (r_state != S_IDLE) &&
                     (r_state != S_READY);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_loss     <= '0;
         r_sync     <= '0;
         r_retry    <= 8'h00;
         r_tx_reset <= 1'b0;
         r_tx_wake  <= 1'b0;
         r_tx_idle  <= 1'b1;
         r_tx_dout  <= 32'h0;
         r_tx_isk   <= 1'b0;
         r_linkup   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_enter)
            r_cnt <= '0;
         else if (w_cnt_en)
            r_cnt <= r_cnt + 1'b1;
         if (w_enter || r_state != S_READY ||
             !oob.rx_elec_idle)
            r_loss <= '0;
         else
            r_loss <= r_loss + 1'b1;
         if (w_enter || r_state != S_SEND_ALIGN ||
             w_rx_align)
            r_sync <= '0;
         else
            r_sync <= r_sync + 1'b1;
         if (w_retry && r_retry != 8'hFF)
            r_retry <= r_retry + 8'h01;
         r_tx_reset <= w_tx_reset;
         r_tx_wake  <= w_tx_wake;
         r_tx_idle  <= w_tx_idle;
         r_tx_dout  <= w_tx_dout;
         r_tx_isk   <= w_tx_isk;
         r_linkup   <= w_linkup;
      end
   end

   assign oob.tx_comm_reset = r_tx_reset;
   assign oob.tx_comm_wake  = r_tx_wake;
   assign oob.tx_elec_idle  = r_tx_idle;
   assign oob.phy_tx_dout   = r_tx_dout;
   assign oob.phy_tx_isk    = r_tx_isk;
   assign oob.linkup        = r_linkup;
   assign oob.oob_state     = r_state;
   assign oob.retry_count   = r_retry;

endmodule

// File: tb/tb_sata_oob_controller.sv
// Bench for sata_oob_controller: reactive PHY model plus
// per-scenario tasks checked against rule-derived expectations.
`timescale 1ns/1ps
module tb_sata_oob_controller;
   localparam int PULSE   = 16;
   localparam int INIT_T  = 120;
   localparam int ALIGN_T = 400;
   localparam int SYNC_N  = 3;
   localparam int LOSS_N  = 1024;
   localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
   localparam logic [31:0] D10_W   = 32'h4A4A4A4A;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   sata_oob_controller_if oob();

   sata_oob_controller #(
      .COMM_PULSE(PULSE),
      .INIT_TIMEOUT(INIT_T),
      .ALIGN_TIMEOUT(ALIGN_T),
      .SYNC_COUNT(SYNC_N),
      .LOSS_CYCLES(LOSS_N)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .oob(oob.master)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: sim time exceeded, errors=%0d", errors);
      $fatal(1);
   end

   logic [3:0] seq[$];
   int         rst_w[$];
   int         wake_w[$];
   bit         d10_bad;
   bit         d10_seen;

   task automatic drive_align();
      oob.phy_rx_din = ALIGN_W;
      oob.phy_rx_isk = 4'b0001;
   endtask

   // Any dword that is not a K-flagged ALIGN; sometimes the
   // ALIGN pattern with wrong K flags, which must not match.
   task automatic drive_nonalign();
      logic [31:0] d;
      d = $urandom;
      if (d == ALIGN_W) d = ~d;
      if ($urandom_range(0, 3) == 0) begin
         oob.phy_rx_din = ALIGN_W;
         oob.phy_rx_isk = 4'b0000;
      end else begin
         oob.phy_rx_din = d;
         oob.phy_rx_isk = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic do_reset();
      oob.platform_ready     = 1'b0;
      oob.oob_restart        = 1'b0;
      oob.comm_init_detect   = 1'b0;
      oob.comm_wake_detect   = 1'b0;
      oob.rx_elec_idle       = 1'b1;
      oob.rx_byte_is_aligned = 1'b0;
      oob.phy_rx_din         = 32'h0;
      oob.phy_rx_isk         = 4'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget,
                             output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (oob.oob_state == s) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // PHY model: COMINIT 40 cycles after COMRESET ends, COMWAKE 40
   // after wake ends (rx leaves idle), ALIGN 200 cycles later, then
   // after 5 ALIGNs seen in SEND_ALIGN, random non-ALIGN traffic.
   task automatic bring_up(input logic [3:0] stop_at, input int budget,
                           output bit reached);
      int t_init, t_wake, t_align, a_cnt, crw, cww;
      t_init = -1; t_wake = -1; t_align = -1;
      a_cnt = 0; crw = 0; cww = 0;
      seq.delete(); rst_w.delete(); wake_w.delete();
      d10_bad = 1'b0; d10_seen = 1'b0;
      reached = 1'b0;
      seq.push_back(oob.oob_state);
      oob.platform_ready = 1'b1;
      for (int now = 0; now < budget; now++) begin
         @(negedge clk);
         if (seq[$] != oob.oob_state) seq.push_back(oob.oob_state);
         if (oob.tx_comm_reset) crw++;
         else if (crw > 0) begin
            rst_w.push_back(crw); crw = 0; t_init = now + 40;
         end
         if (oob.tx_comm_wake) cww++;
         else if (cww > 0) begin
            wake_w.push_back(cww); cww = 0; t_wake = now + 40;
         end
         if (oob.oob_state == 4'd6) begin
            d10_seen = 1'b1;
            if (oob.phy_tx_dout !== D10_W || oob.phy_tx_isk !== 1'b0 ||
                oob.tx_elec_idle !== 1'b0)
               d10_bad = 1'b1;
         end
         if (oob.oob_state == stop_at) begin
            reached = 1'b1;
            break;
         end
         oob.comm_init_detect = (now == t_init);
         oob.comm_wake_detect = (now == t_wake);
         if (now == t_wake) oob.rx_elec_idle = 1'b0;
         if (t_wake >= 0 && now == t_wake + 200) t_align = now;
         if (t_align >= 0) begin
            oob.rx_byte_is_aligned = 1'b1;
            if (oob.oob_state == 4'd7) a_cnt++;
            if (a_cnt > 4) drive_nonalign();
            else drive_align();
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (oob.oob_state !== 4'd0) begin
         errors++; $display("FAIL reset_state: got %0d want 0", oob.oob_state);
      end
      checks++;
      if (oob.tx_elec_idle !== 1'b1 || oob.tx_comm_reset !== 1'b0 ||
          oob.tx_comm_wake !== 1'b0 || oob.linkup !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: idle=%b rst=%b wake=%b link=%b want 1000",
                  oob.tx_elec_idle, oob.tx_comm_reset,
                  oob.tx_comm_wake, oob.linkup);
      end
      checks++;
      if (oob.phy_tx_dout !== 32'h0 || oob.phy_tx_isk !== 1'b0 ||
          oob.retry_count !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: dout=%h isk=%b retry=%0d want 0/0/0",
                  oob.phy_tx_dout, oob.phy_tx_isk, oob.retry_count);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (oob.oob_state !== 4'd0) begin
         errors++;
         $display("FAIL idle_hold: got %0d want 0 without platform_ready",
                  oob.oob_state);
      end
   endtask

   task automatic test_bringup();
      bit ok;
      bit seq_ok;
      do_reset();
      bring_up(4'd8, 3000, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL bringup_reach: READY not reached, state=%0d",
                            oob.oob_state);
      end
      seq_ok = (seq.size() == 9);
      for (int i = 0; i < seq.size() && i < 9; i++)
         if (seq[i] != 4'(i)) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin
         errors++;
         $display("FAIL bringup_seq: %0d states visited, last %0d; want 0..8",
                  seq.size(), seq[$]);
      end
      checks++;
      if (oob.linkup !== 1'b1 || oob.retry_count !== 8'h00) begin
         errors++;
         $display("FAIL bringup_link: linkup=%b retry=%0d want 1/0",
                  oob.linkup, oob.retry_count);
      end
      checks++;
      if (rst_w.size() < 1 || rst_w[0] != PULSE) begin
         errors++;
         $display("FAIL reset_pulse_len: got %0d want %0d",
                  rst_w.size() ? rst_w[0] : -1, PULSE);
      end
      checks++;
      if (wake_w.size() < 1 || wake_w[0] != PULSE) begin
         errors++;
         $display("FAIL wake_pulse_len: got %0d want %0d",
                  wake_w.size() ? wake_w[0] : -1, PULSE);
      end
      checks++;
      if (!d10_seen || d10_bad) begin
         errors++;
         $display("FAIL d10_tx: seen=%b bad=%b want 1/0", d10_seen, d10_bad);
      end
      checks++;
      if (oob.phy_tx_dout !== ALIGN_W || oob.phy_tx_isk !== 1'b1 ||
          oob.tx_elec_idle !== 1'b0) begin
         errors++;
         $display("FAIL ready_tx: dout=%h isk=%b idle=%b want %h/1/0",
                  oob.phy_tx_dout, oob.phy_tx_isk, oob.tx_elec_idle, ALIGN_W);
      end
   endtask

   task automatic test_retry_saturation();
      int rises, last, exp_r;
      logic prev;
      do_reset();
      oob.platform_ready = 1'b1;
      rises = 0; last = -1; prev = 1'b0;
      for (int now = 0; now < (PULSE + INIT_T) * 262 && rises < 260; now++) begin
         @(negedge clk);
         if (oob.tx_comm_reset && !prev) begin
            exp_r = (rises > 255) ? 255 : rises;
            checks++;
            if (oob.retry_count !== 8'(exp_r)) begin
               errors++;
               $display("FAIL retry_count[%0d]: got %0d want %0d",
                        rises, oob.retry_count, exp_r);
            end
            if (last >= 0) begin
               checks++;
               if (now - last != PULSE + INIT_T) begin
                  errors++;
                  $display("FAIL retry_period[%0d]: got %0d want %0d",
                           rises, now - last, PULSE + INIT_T);
               end
            end
            last = now;
            rises++;
         end
         prev = oob.tx_comm_reset;
      end
      checks++;
      if (rises != 260) begin
         errors++; $display("FAIL retry_rises: got %0d want 260", rises);
      end
      checks++;
      if (oob.retry_count !== 8'hFF) begin
         errors++;
         $display("FAIL retry_sat: got %0d want 255", oob.retry_count);
      end
   endtask

   task automatic test_link_loss();
      bit ok;
      logic [7:0] r0;
      do_reset();
      bring_up(4'd8, 3000, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL loss_setup: state=%0d want 8", oob.oob_state);
      end
      r0 = oob.retry_count;
      oob.rx_elec_idle = 1'b1;
      repeat (LOSS_N - 1) @(negedge clk);
      oob.rx_elec_idle = 1'b0;
      @(negedge clk);
      checks++;
      if (oob.oob_state !== 4'd8 || oob.linkup !== 1'b1) begin
         errors++;
         $display("FAIL loss_1023: state=%0d link=%b want 8/1",
                  oob.oob_state, oob.linkup);
      end
      oob.rx_elec_idle = 1'b1;
      repeat (LOSS_N - 1) @(negedge clk);
      checks++;
      if (oob.oob_state !== 4'd8) begin
         errors++;
         $display("FAIL loss_early: state=%0d want 8", oob.oob_state);
      end
      @(negedge clk);
      checks++;
      if (oob.oob_state !== 4'd1 || oob.linkup !== 1'b0 ||
          oob.tx_comm_reset !== 1'b1 || oob.retry_count !== r0) begin
         errors++;
         $display("FAIL loss_1024: state=%0d link=%b rst=%b retry=%0d want 1/0/1/%0d",
                  oob.oob_state, oob.linkup, oob.tx_comm_reset,
                  oob.retry_count, r0);
      end
   endtask

   task automatic test_ready_exits();
      bit ok;
      do_reset();
      bring_up(4'd8, 3000, ok);
      oob.comm_init_detect = 1'b1;
      @(negedge clk);
      oob.comm_init_detect = 1'b0;
      checks++;
      if (!ok || oob.oob_state !== 4'd1 || oob.linkup !== 1'b0 ||
          oob.retry_count !== 8'h00) begin
         errors++;
         $display("FAIL ready_cominit: state=%0d link=%b retry=%0d want 1/0/0",
                  oob.oob_state, oob.linkup, oob.retry_count);
      end
      repeat (3) @(negedge clk);
      oob.platform_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (oob.oob_state !== 4'd0 || oob.tx_comm_reset !== 1'b0 ||
          oob.tx_elec_idle !== 1'b1) begin
         errors++;
         $display("FAIL platform_drop: state=%0d rst=%b idle=%b want 0/0/1",
                  oob.oob_state, oob.tx_comm_reset, oob.tx_elec_idle);
      end
   endtask

   task automatic test_sync_run();
      bit ok;
      bit pat[6];
      int run;
      logic [3:0] exp_s;
      pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      bring_up(4'd7, 3000, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL sync_setup: state=%0d want 7", oob.oob_state);
      end
      drive_align();
      repeat (2) @(negedge clk);
      run = 0;
      for (int i = 0; i < 6; i++) begin
         if (pat[i]) drive_align();
         else drive_nonalign();
         @(negedge clk);
         run = pat[i] ? 0 : run + 1;
         exp_s = (run >= SYNC_N) ? 4'd8 : 4'd7;
         checks++;
         if (oob.oob_state !== exp_s) begin
            errors++;
            $display("FAIL sync_step[%0d]: got %0d want %0d",
                     i, oob.oob_state, exp_s);
         end
      end
      checks++;
      if (oob.linkup !== 1'b1) begin
         errors++; $display("FAIL sync_linkup: got %b want 1", oob.linkup);
      end
   endtask

   task automatic test_restart_and_reset();
      bit ok;
      logic [7:0] r0;
      do_reset();
      bring_up(4'd6, 3000, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL restart_setup: state=%0d want 6", oob.oob_state);
      end
      r0 = oob.retry_count;
      oob.oob_restart = 1'b1;
      @(negedge clk);
      oob.oob_restart = 1'b0;
      checks++;
      if (oob.oob_state !== 4'd1 || oob.retry_count !== r0 ||
          oob.tx_comm_reset !== 1'b1 || oob.tx_elec_idle !== 1'b1) begin
         errors++;
         $display("FAIL restart: state=%0d retry=%0d rst=%b idle=%b want 1/%0d/1/1",
                  oob.oob_state, oob.retry_count, oob.tx_comm_reset,
                  oob.tx_elec_idle, r0);
      end
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (oob.tx_comm_reset !== 1'b0 || oob.tx_elec_idle !== 1'b1 ||
          oob.oob_state !== 4'd0) begin
         errors++;
         $display("FAIL midpulse_reset: rst=%b idle=%b state=%0d want 0/1/0",
                  oob.tx_comm_reset, oob.tx_elec_idle, oob.oob_state);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_detect_vs_timeout();
      bit ok;
      do_reset();
      oob.platform_ready = 1'b1;
      wait_state(4'd2, 100, ok);
      repeat (INIT_T - 1) @(negedge clk);
      checks++;
      if (!ok || oob.oob_state !== 4'd2) begin
         errors++;
         $display("FAIL timeout_early: state=%0d want 2", oob.oob_state);
      end
      @(negedge clk);
      checks++;
      if (oob.oob_state !== 4'd1 || oob.retry_count !== 8'd1) begin
         errors++;
         $display("FAIL timeout_expire: state=%0d retry=%0d want 1/1",
                  oob.oob_state, oob.retry_count);
      end
      wait_state(4'd2, 100, ok);
      repeat (INIT_T - 1) @(negedge clk);
      oob.comm_init_detect = 1'b1;
      @(negedge clk);
      oob.comm_init_detect = 1'b0;
      checks++;
      if (!ok || oob.oob_state !== 4'd3 || oob.retry_count !== 8'd1) begin
         errors++;
         $display("FAIL detect_wins: state=%0d retry=%0d want 3/1",
                  oob.oob_state, oob.retry_count);
      end
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_sync_run();
      test_link_loss();
      test_ready_exits();
      test_restart_and_reset();
      test_detect_vs_timeout();
      test_retry_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
